mfp_seven_segment_display_scheduler: RTL and testbench

- Timing and sequencing controller for the 8-digit multiplexed seven-segment display.
- Accepts new display content from a bus-side requester through a valid/ready handshake and holds it in a shadow register.
- Commits the shadow content only at frame boundaries, so a digit never shows half-updated data.
- Generates per-digit refresh timing with anti-ghosting blank intervals, per-digit enable, dot control and leading-zero suppression.

---
 rtl/mfp_seven_segment_display_scheduler.sv | 148 ++++++++++++++
 tb/tb_mfp_seven_segment_display_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_seven_segment_display_scheduler.sv
// Refresh scheduler for an 8-digit multiplexed seven-segment display.
// A shadow register holds new content until the frame boundary, so digits never show half-updated data.
module mfp_seven_segment_display_scheduler #(
  parameter int unsigned REFRESH_DIV  = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_number,
  input  logic [7:0]  wr_dot_mask,
  input  logic [7:0]  wr_digit_en,
  input  logic        wr_lz_blank,
  output logic [6:0]  seven_segments,
  output logic        dot,
  output logic [7:0]  anodes,
  output logic        frame_start
);

  localparam int unsigned NUM_W  = 32;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned SEG_W  = 7;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  typedef struct packed {
    logic [NUM_W-1:0]  number;
    logic [DIGITS-1:0] dot_mask;
    logic [DIGITS-1:0] digit_en;
    logic              lz_blank;
  } content_t;

  localparam content_t ACTIVE_RST = '{number: '0, dot_mask: '0, digit_en: 8'hFF, lz_blank: 1'b0};

  // Active-low font, bit0 = segment a through bit6 = segment g.
  function automatic logic [SEG_W-1:0] hexfont(input logic [3:0] v);
    case (v)
      4'h0:    hexfont = 7'h40;
      4'h1:    hexfont = 7'h79;
      4'h2:    hexfont = 7'h24;
      4'h3:    hexfont = 7'h30;
      4'h4:    hexfont = 7'h19;
      4'h5:    hexfont = 7'h12;
      4'h6:    hexfont = 7'h02;
      4'h7:    hexfont = 7'h78;
      4'h8:    hexfont = 7'h00;
      4'h9:    hexfont = 7'h10;
      4'hA:    hexfont = 7'h08;
      4'hB:    hexfont = 7'h03;
      4'hC:    hexfont = 7'h46;
      4'hD:    hexfont = 7'h21;
      4'hE:    hexfont = 7'h06;
      default: hexfont = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       slot_q, slot_d;
  logic             pending_q, pending_d;
  content_t         shadow_q, shadow_d;
  content_t         active_q, active_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dot_q, dot_d;
  logic [7:0]       anodes_q, anodes_d;
  logic             frame_start_q, frame_start_d;

  logic             boundary;
  logic [3:0]       digit;
  logic [NUM_W-1:0] upper;
  logic             visible;

  assign wr_ready       = !pending_q;
  assign seven_segments = seg_q;
  assign dot            = dot_q;
  assign anodes         = anodes_q;
  assign frame_start    = frame_start_q;

  // Slot timing, handshake capture and frame-boundary commit.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    slot_d    = slot_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    boundary  = (cnt_q == CNT_LAST) && (slot_q == 3'd7);

    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = slot_q + 3'd1;
    end

    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (wr_valid && !pending_q) begin
      shadow_d  = '{number: wr_number, dot_mask: wr_dot_mask, digit_en: wr_digit_en, lz_blank: wr_lz_blank};
      pending_d = 1'b1;
    end
  end

  // Digit drive; leading-zero suppression never hides digit 0.
  always_comb begin
    digit         = active_q.number[{slot_q, 2'b00} +: 4];
    upper         = active_q.number >> {slot_q, 2'b00};
    visible       = active_q.digit_en[slot_q] &&
                    !(active_q.lz_blank && (slot_q != 3'd0) && (upper == '0));
    anodes_d      = 8'hFF;
    seg_d         = 7'h7F;
    dot_d         = 1'b1;
    frame_start_d = boundary;

    if (cnt_q >= CNT_BLANK) begin
      seg_d = hexfont(digit);
      dot_d = ~active_q.dot_mask[slot_q];
      if (visible) anodes_d = ~(8'd1 << slot_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      pending_q     <= 1'b0;
      shadow_q      <= '0;
      active_q      <= ACTIVE_RST;
      seg_q         <= 7'h7F;
      dot_q         <= 1'b1;
      anodes_q      <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      seg_q         <= seg_d;
      dot_q         <= dot_d;
      anodes_q      <= anodes_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_mfp_seven_segment_display_scheduler.sv
// Scoreboard bench: stimulus queues per-slot expectations tagged by frame, a negedge monitor checks them.
module tb_mfp_seven_segment_display_scheduler;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 8 * RDIV;
  localparam int unsigned TMO   = 4 * FRAME;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_number = '0;
  logic [7:0]  wr_dot_mask = '0;
  logic [7:0]  wr_digit_en = '0;
  logic        wr_lz_blank = 1'b0;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [7:0]  anodes;
  logic        frame_start;

  mfp_seven_segment_display_scheduler #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK),
    .CNT_W       (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_number     (wr_number),
    .wr_dot_mask   (wr_dot_mask),
    .wr_digit_en   (wr_digit_en),
    .wr_lz_blank   (wr_lz_blank),
    .seven_segments(seven_segments),
    .dot           (dot),
    .anodes        (anodes),
    .frame_start   (frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         frame;
    int         slot;
    bit         dark;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   frame_no = 0;

  logic [6:0] b_seg [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, expected event never came", name);
  endtask

  task automatic push(input int f, input int s, input bit dark, input logic [6:0] seg, input logic d);
    exp_t       e;
    logic [7:0] one;
    one     = 8'd1;
    e.frame = f;
    e.slot  = s;
    e.dark  = dark;
    e.an    = dark ? 8'hFF : ~(one << s);
    e.seg   = seg;
    e.dt    = d;
    sb.push_back(e);
  endtask

  task automatic check_slot(input int s);
    exp_t e;
    while (sb.size() > 0 && (sb[0].frame < frame_no || (sb[0].frame == frame_no && sb[0].slot < s))) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_f%0d_s%0d: got no sample, expected a display check", e.frame, e.slot);
    end
    if (sb.size() > 0 && sb[0].frame == frame_no && sb[0].slot == s) begin
      e = sb.pop_front();
      if (e.dark) chk($sformatf("dark_f%0d_s%0d", e.frame, s), 32'(anodes), 32'hFF);
      else chk($sformatf("show_f%0d_s%0d", e.frame, s), 32'({anodes, seven_segments, dot}),
               32'({e.an, e.seg, e.dt}));
    end
  endtask

  // Monitor: k counts cycles since the last frame_start; sample slot s at cnt 0 and cnt 4.
  int k  = 0;
  bit fv = 1'b0;
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      fv = 1'b0;
      k  = 0;
    end else begin
      if (frame_start) begin
        frame_no++;
        fv = 1'b1;
        k  = 0;
      end else if (fv) begin
        k++;
      end
      if (fv && k < int'(FRAME)) begin
        if (k % RDIV == 1)
          chk($sformatf("blank_f%0d_s%0d", frame_no, k / RDIV), 32'({anodes, seven_segments, dot}),
              32'({8'hFF, 7'h7F, 1'b1}));
        if (k % RDIV == 5) check_slot(k / RDIV);
      end
    end
  end

  bit         ghost_en = 1'b0;
  bit         had_lit  = 1'b0;
  int         ff_run   = 0;
  logic [7:0] last_lit = 8'hFF;
  always @(negedge clock) begin
    if (ghost_en) begin
      chk("one_anode_max", 32'($countones(~anodes) <= 1), 32'd1);
      if (anodes == 8'hFF) begin
        ff_run++;
      end else begin
        if (had_lit && anodes != last_lit) chk("blank_gap", 32'(ff_run), 32'(BLANK));
        had_lit  = 1'b1;
        last_lit = anodes;
        ff_run   = 0;
      end
    end
  end

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (!frame_start && cyc < int'(TMO));
    if (!frame_start) fail_now("frame_start_wait");
  endtask

  task automatic wait_mid();
    int c;
    wait_frame(c);
    repeat (10) begin @(posedge clock); #1; end
  endtask

  task automatic do_write(input logic [31:0] num, input logic [7:0] dm, input logic [7:0] en,
                          input logic lz, output bit at_fs);
    int t;
    t           = 0;
    wr_valid    = 1'b1;
    wr_number   = num;
    wr_dot_mask = dm;
    wr_digit_en = en;
    wr_lz_blank = lz;
    while (!wr_ready && t < int'(TMO)) begin
      @(posedge clock); #1;
      t++;
    end
    if (!wr_ready) fail_now("write_accept_wait");
    at_fs = frame_start;
    @(posedge clock); #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    int c;
    int f;
    bit fs;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_anodes", 32'(anodes), 32'hFF);
    chk("reset_segments", 32'(seven_segments), 32'h7F);
    chk("reset_dot", 32'(dot), 32'd1);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    chk("ready_after_reset", 32'(wr_ready), 32'd1);
    wait_frame(c);
    chk("first_frame_start_cycle", 32'(c), 32'(FRAME));
    repeat (10) begin @(posedge clock); #1; end

    // Default content: every digit shows 0; also watch anode gaps over three frames.
    for (int s = 0; s < 8; s++) push(frame_no + 1, s, 1'b0, 7'h40, 1'b1);
    ghost_en = 1'b1;
    wait_mid();
    wait_mid();
    wait_mid();
    ghost_en = 1'b0;

    do_write(32'h0000_1234, 8'h01, 8'hFF, 1'b1, fs);
    f = frame_no + 1;
    push(f, 0, 1'b0, 7'h19, 1'b0);
    push(f, 1, 1'b0, 7'h30, 1'b1);
    push(f, 2, 1'b0, 7'h24, 1'b1);
    push(f, 3, 1'b0, 7'h79, 1'b1);
    for (int s = 4; s < 8; s++) push(f, s, 1'b1, 7'h7F, 1'b1);
    wait_mid();

    // Back-to-back writes: A shows for one frame, B is held until the frame_start cycle.
    do_write(32'h8888_8888, 8'h00, 8'hFF, 1'b0, fs);
    chk("ready_low_after_a", 32'(wr_ready), 32'd0);
    f = frame_no;
    for (int s = 0; s < 8; s++) push(f + 1, s, 1'b0, 7'h00, 1'b1);
    for (int s = 0; s < 8; s++) push(f + 2, s, 1'b0, b_seg[s], (s % 2 == 0));
    do_write(32'h7654_3210, 8'hAA, 8'hFF, 1'b0, fs);
    chk("b_accepted_in_frame_start_cycle", 32'(fs), 32'd1);
    wait_mid();

    do_write(32'h0000_0000, 8'h00, 8'hFF, 1'b1, fs);
    f = frame_no + 1;
    push(f, 0, 1'b0, 7'h40, 1'b1);
    for (int s = 1; s < 8; s++) push(f, s, 1'b1, 7'h7F, 1'b1);
    wait_mid();

    do_write(32'hF000_0000, 8'h00, 8'h7F, 1'b0, fs);
    f = frame_no + 1;
    for (int s = 0; s < 7; s++) push(f, s, 1'b0, 7'h40, 1'b1);
    push(f, 7, 1'b1, 7'h7F, 1'b1);
    wait_mid();
    wait_mid();

    // Reset in slot 5 with a write pending: it must be discarded.
    do_write(32'h1111_1111, 8'hFF, 8'hFF, 1'b0, fs);
    chk("pending_before_reset", 32'(wr_ready), 32'd0);
    repeat (32) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk("midreset_anodes", 32'(anodes), 32'hFF);
    chk("midreset_segments", 32'(seven_segments), 32'h7F);
    chk("midreset_dot", 32'(dot), 32'd1);
    chk("midreset_frame_start", 32'(frame_start), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("ready_after_midreset", 32'(wr_ready), 32'd1);
    wait_frame(c);
    chk("frame_start_after_midreset", 32'(c), 32'(FRAME));
    f = frame_no + 1;
    for (int s = 0; s < 8; s++) push(f, s, 1'b0, 7'h40, 1'b1);
    wait_frame(c);
    repeat (2) begin @(posedge clock); #1; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
